// File: rtl/ysyx_23060171_bus_arbiter.sv
// ysyx_23060171_bus_arbiter
//   Multiplexes NR_CH valid/ready masters onto one downstream slave port.
//   A grant is registered and held for a complete request/response
//   transaction (IDLE -> REQ -> RESP). Selection is fixed priority
//   (MODE=0, channel 0 highest) or round-robin (MODE=1).
//
// Ports
//   clock, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready       : per-master request handshake
//   in_data                 : packed request payloads, channel n at [DATA_LEN*(n+1)-1 -: DATA_LEN]
//   out_valid/out_ready     : downstream request handshake
//   out_data, out_id        : registered payload and granted channel index
//   sresp_valid/sresp_ready : downstream response handshake
//   sresp_data              : downstream response payload
//   resp_valid/resp_ready   : per-master response handshake (granted channel only)
//   resp_data               : response payload, broadcast to all masters
module ysyx_23060171_bus_arbiter #(
    parameter  int NR_CH    = 2,
    parameter  int DATA_LEN = 32,
    parameter  int RESP_LEN = 32,
    parameter  int MODE     = 0,
    localparam int ID_LEN   = (NR_CH > 1) ? $clog2(NR_CH) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NR_CH-1:0]          in_valid,
    output logic [NR_CH-1:0]          in_ready,
    input  logic [NR_CH*DATA_LEN-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_LEN-1:0]       out_data,
    output logic [ID_LEN-1:0]         out_id,
    input  logic                      sresp_valid,
    output logic                      sresp_ready,
    input  logic [RESP_LEN-1:0]       sresp_data,
    output logic [NR_CH-1:0]          resp_valid,
    input  logic [NR_CH-1:0]          resp_ready,
    output logic [RESP_LEN-1:0]       resp_data
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                            state, state_nxt;
    logic   [ID_LEN-1:0]               grant, rr_ptr, rr_nxt, win;
    logic   [DATA_LEN-1:0]             payload;
    logic   [NR_CH-1:0][DATA_LEN-1:0]  in_vec;
    logic   [NR_CH-1:0]                hi_req, pick;
    logic                              any_vld, accept, grant_ready;

    assign in_vec = in_data;

    // Winner selection. Round-robin first looks at channels at or above
    // rr_ptr; if none of those request, it wraps to the lowest requester.
    // In fixed-priority mode hi_req is empty, so the lowest requester wins.
    always_comb begin
        hi_req = '0;
        for (int i = 0; i < NR_CH; i++)
            hi_req[i] = in_valid[i] && (MODE == 1) && (i >= int'(rr_ptr));
        pick = (|hi_req) ? hi_req : in_valid;
        win  = '0;
        for (int i = NR_CH - 1; i >= 0; i--)
            if (pick[i]) win = ID_LEN'(i);
    end

    assign any_vld = |in_valid;
    assign accept  = (state == IDLE) && any_vld;
    assign rr_nxt  = (int'(win) == NR_CH - 1) ? '0 : win + 1'b1;

    // Ready of the granted master, selected without a variable index.
    always_comb begin
        grant_ready = 1'b0;
        for (int i = 0; i < NR_CH; i++)
            if (grant == ID_LEN'(i)) grant_ready = resp_ready[i];
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Transaction registers change only on an IDLE accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant   <= '0;
            rr_ptr  <= '0;
            payload <= '0;
        end else if (accept) begin
            grant   <= win;
            payload <= in_vec[win];
            if (MODE == 1) rr_ptr <= rr_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_vld) state_nxt = REQ;
            REQ:     if (out_ready) state_nxt = RESP;
            RESP:    if (sresp_valid && grant_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. in_ready is gated by reset explicitly: the state flop
    // already reads IDLE during reset, where in_ready would otherwise follow
    // in_valid combinationally.
    always_comb begin
        in_ready    = '0;
        resp_valid  = '0;
        out_valid   = !reset && (state == REQ);
        sresp_ready = !reset && (state == RESP) && grant_ready;
        for (int i = 0; i < NR_CH; i++) begin
            in_ready[i]   = !reset && (state == IDLE) && any_vld && (win == ID_LEN'(i));
            resp_valid[i] = !reset && (state == RESP) && sresp_valid && (grant == ID_LEN'(i));
        end
    end

    assign out_data  = payload;
    assign out_id    = grant;
    assign resp_data = sresp_data;

endmodule

// File: doc/ysyx_23060171_bus_arbiter.md
# ysyx_23060171_bus_arbiter

Parametrised N-channel request/response arbiter that multiplexes several valid/ready masters onto one downstream slave port and routes the response back to the granted master. It sits between the NPC's masters (IFU, LSU, later DMA) and the shared memory bus. Unlike the combinational key selector, it holds a registered grant for a full request/response transaction and supports fixed-priority or round-robin selection.

## Interface
- NR_CH, 2, number of master channels (≥1)
- DATA_LEN, 32, request payload width per channel
- RESP_LEN, 32, response payload width
- MODE, 0, 0 = fixed priority (channel 0 highest), 1 = round-robin
- ID_LEN, derived: max(1, clog2(NR_CH)), width of channel id
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  NR_CH  per-master request valid
- in_ready  output  NR_CH  per-master request ready
- in_data  input  NR_CH*DATA_LEN  packed request payloads, channel n at [DATA_LEN*(n+1)-1 : DATA_LEN*n]
- out_valid  output  1  downstream request valid
- out_ready  input  1  downstream request ready
- out_data  output  DATA_LEN  downstream request payload
- out_id  output  ID_LEN  index of granted channel
- sresp_valid  input  1  downstream response valid
- sresp_ready  output  1  downstream response ready
- sresp_data  input  RESP_LEN  downstream response payload
- resp_valid  output  NR_CH  per-master response valid
- resp_ready  input  NR_CH  per-master response ready
- resp_data  output  RESP_LEN  response payload, broadcast to all channels

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: winner W computed combinationally from in_valid. in_ready[W]=1 if any in_valid, all other in_ready=0. On handshake (in_valid[W] & in_ready[W]): capture in_data[W] into payload register, grant<=W, go REQ. No valid -> stay IDLE.
- Selection, MODE=0: W = lowest index with in_valid set.
- Selection, MODE=1: search starts at rr_ptr, ascending, wrapping modulo NR_CH. On every IDLE accept, rr_ptr<=(W+1) mod NR_CH. MODE=0 never updates rr_ptr.
- REQ: out_valid=1, out_data=payload register, out_id=grant. All in_ready=0. On out_ready, go RESP.
- RESP: resp_valid[grant]=sresp_valid, other resp_valid=0. sresp_ready=resp_ready[grant]. resp_data=sresp_data. On sresp_valid & resp_ready[grant], go IDLE.
- Outside RESP: sresp_ready=0, all resp_valid=0, and sresp_valid is ignored.
- out_data/out_id hold the registered value in every state. out_valid is 1 only in REQ.
- NR_CH=1: W is always 0, out_id is 1'b0, rr_ptr stays 0.
- Payload, grant and rr_ptr change only on an IDLE accept.

## Timing
- Reset (asynchronous assert; synchronous-to-clock deassert expected): state=IDLE, grant=0, rr_ptr=0, payload=0.
  - While reset is high: in_ready=0, out_valid=0, out_id=0, out_data=0, sresp_ready=0, resp_valid=0.
- Reset mid-transaction: the in-flight transaction is dropped and the FSM returns to IDLE. Downstream must be reset with it.
- Latency:
  - Accept at edge k; out_valid high from cycle k+1.
  - Response forwarded combinationally, zero-cycle, in RESP.
- Minimum transaction is 3 cycles (IDLE, REQ, RESP), so throughput is at most 1 transaction per 3 cycles.
- Back-to-back requests: the next IDLE accept occurs in the cycle after the response handshake.
- in_valid dropping before accept is tolerated; the winner is re-evaluated every IDLE cycle.
- Simultaneous requests are resolved only in IDLE. A new in_valid during REQ/RESP waits.
- Downstream stall (out_ready=0, or no sresp_valid) holds the FSM indefinitely with all outputs stable.

## Test plan
- Reset: assert reset mid-REQ with out_valid=1 -> out_valid, in_ready and resp_valid drop to 0 immediately (asynchronous, before the next edge); after release, state is IDLE and out_id=0.
- Single request, NR_CH=2, MODE=0: in_valid=2'b10, in_data[63:32]=32'hDEADBEEF, out_ready=1, sresp_data=32'h1234 with sresp_valid at cycle 2 -> in_ready=2'b10 at cycle 0; out_valid, out_data=32'hDEADBEEF and out_id=1 at cycle 1; resp_valid=2'b10 and resp_data=32'h1234 at cycle 2; back in IDLE at cycle 3.
- Fixed-priority contention: in_valid=2'b11 held for 4 transactions -> channel 0 granted every time; channel 1 starves.
- Round-robin, NR_CH=4, MODE=1: all in_valid held high -> out_id sequence 0,1,2,3,0; with in_valid=4'b1001 after a grant to 0 -> next grant is 3.
- Backpressure: out_ready=0 for 5 cycles, then resp_ready[grant]=0 for 3 cycles with sresp_valid=1 -> out_data/out_id stable, no in_ready asserted, sresp_ready=0 until resp_ready rises, one completion only.
- Stray response: sresp_valid=1 in IDLE -> sresp_ready=0 and resp_valid=0; the FSM does not change state.
